// File: rtl/video_spi_rx_pkg.sv
// Shared types and constants for the serial video link receiver.
package video_spi_rx_pkg;

  localparam int unsigned VIDEO_W     = 12;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECV      = 2'd2
  } rx_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
    return (&v) ? v : v + FRAME_CNT_W'(1);
  endfunction

endpackage

// File: rtl/video_rx_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module video_rx_fifo #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_req,
  output logic              full,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_req,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              wr_en, rd_en;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign rd_en   = rd_req && !empty;
  assign wr_en   = wr_req && (!full || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/video_spi_rx.sv
// Serial video link receiver: synchronizes slv/sckv/sdatav, deserializes
// MSB-first words and buffers them onto a valid/ready stream.
module video_spi_rx import video_spi_rx_pkg::*; #(
  parameter int unsigned DATA_W      = VIDEO_W,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          CPOL        = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slv,
  input  logic              sckv,
  input  logic              sdatav,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overflow,
  output logic [15:0]       frame_words,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  rx_state_e                state_q, state_d;
  logic [SYNC_STAGES-1:0]   slv_sync_q, slv_sync_d;
  logic [SYNC_STAGES-1:0]   sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0]   sd_sync_q, sd_sync_d;
  logic                     sck_prev_q, sck_prev_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]        shift_q, shift_d;
  logic                     push_q, push_d;
  logic [FRAME_CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [FRAME_CNT_W-1:0]   frame_words_q, frame_words_d;
  logic                     frame_err_q, frame_err_d;
  logic                     overflow_q, overflow_d;
  logic                     busy_q, busy_d;

  logic              slv_s, sck_s, sd_s, sample_edge;
  logic              fifo_full, fifo_empty, pop;
  logic [DATA_W-1:0] fifo_rd_data;

  assign slv_s       = slv_sync_q[SYNC_STAGES-1];
  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign sd_s        = sd_sync_q[SYNC_STAGES-1];
  assign sample_edge = CPOL ? (sck_prev_q & ~sck_s) : (sck_s & ~sck_prev_q);

  assign out_valid   = ~fifo_empty;
  assign out_data    = out_valid ? fifo_rd_data : '0;
  assign pop         = out_valid & out_ready;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
  assign frame_words = frame_words_q;
  assign busy        = busy_q;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    push_d        = 1'b0;
    word_cnt_d    = word_cnt_q;
    frame_words_d = frame_words_q;
    frame_err_d   = 1'b0;
    slv_sync_d    = {slv_sync_q[SYNC_STAGES-2:0], slv};
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], sckv};
    sd_sync_d     = {sd_sync_q[SYNC_STAGES-2:0], sdatav};
    sck_prev_d    = sck_s;
    overflow_d    = push_q & fifo_full & ~pop;

    unique case (state_q)
      // Never lock onto a frame already in flight when reset released.
      WAIT_IDLE: if (slv_s) state_d = IDLE;
      IDLE: begin
        if (!slv_s) begin
          state_d    = RECV;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end
      RECV: begin
        // End of frame wins over a coincident sample edge.
        if (slv_s) begin
          frame_err_d   = (bit_cnt_q != '0);
          frame_words_d = word_cnt_q;
          bit_cnt_d     = '0;
          state_d       = IDLE;
        end else if (sample_edge) begin
          shift_d = {shift_q[DATA_W-2:0], sd_s};
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d  = '0;
            push_d     = 1'b1;
            word_cnt_d = sat_inc(word_cnt_q);
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    busy_d = (state_d == RECV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= WAIT_IDLE;
      slv_sync_q    <= '0;
      sck_sync_q    <= {SYNC_STAGES{CPOL}};
      sd_sync_q     <= '0;
      sck_prev_q    <= CPOL;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      push_q        <= 1'b0;
      word_cnt_q    <= '0;
      frame_words_q <= '0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      slv_sync_q    <= slv_sync_d;
      sck_sync_q    <= sck_sync_d;
      sd_sync_q     <= sd_sync_d;
      sck_prev_q    <= sck_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      push_q        <= push_d;
      word_cnt_q    <= word_cnt_d;
      frame_words_q <= frame_words_d;
      frame_err_q   <= frame_err_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
    end
  end

  // shift_q holds the finished word through the push cycle since sckv <= clk/4.
  video_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (shift_q),
    .wr_req  (push_q),
    .full    (fifo_full),
    .rd_data (fifo_rd_data),
    .rd_req  (pop),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_video_spi_rx.sv
// Directed bench for video_spi_rx: CPOL=0 instance for the main sequence,
// a CPOL=1 instance sharing slv/sdatav for the polarity variant.
module tb_video_spi_rx;

  localparam int unsigned DW = 12;

  logic          clk = 1'b0;
  logic          rst, slv, sck0, sck1, sd, rdy0, rdy1;
  logic [DW-1:0] od0, od1;
  logic          ov0, ov1, fe0, fe1, of0, of1, bz0, bz1;
  logic [15:0]   fw0, fw1;

  int n_cmp = 0;
  int n_err = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  logic [DW-1:0] rxq[$];

  always #5 clk = ~clk;

  video_spi_rx #(.DATA_W(DW), .FIFO_DEPTH(16), .SYNC_STAGES(2), .CPOL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .slv(slv), .sckv(sck0), .sdatav(sd),
    .out_data(od0), .out_valid(ov0), .out_ready(rdy0),
    .frame_err(fe0), .overflow(of0), .frame_words(fw0), .busy(bz0)
  );

  video_spi_rx #(.DATA_W(DW), .FIFO_DEPTH(16), .SYNC_STAGES(2), .CPOL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .slv(slv), .sckv(sck1), .sdatav(sd),
    .out_data(od1), .out_valid(ov1), .out_ready(rdy1),
    .frame_err(fe1), .overflow(of1), .frame_words(fw1), .busy(bz1)
  );

  // Outputs sampled mid-cycle; inputs change 2 time units after posedge.
  always @(negedge clk) begin
    if (ov0 && rdy0) rxq.push_back(od0);
    if (fe0) err_cnt++;
    if (of0) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int i);
    return (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One bit at clk/8; optional one-cycle ready pulse aimed at the push cycle.
  task automatic send_bit(input bit sel, input logic b, input bit hook);
    sd = b;
    tick(2);
    if (sel) sck1 = 1'b0; else sck0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (hook && k == 2) rdy0 = 1'b1;
      if (hook && k == 3) rdy0 = 1'b0;
    end
    if (sel) sck1 = 1'b1; else sck0 = 1'b0;
    tick(2);
  endtask

  task automatic send_word(input bit sel, input logic [DW-1:0] w, input bit pop_last);
    for (int i = DW - 1; i >= 0; i--) send_bit(sel, w[i], pop_last && (i == 0));
  endtask

  task automatic frame_start();
    slv = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    slv = 1'b1;
    tick(6);
  endtask

  initial begin
    rst = 1'b1; slv = 1'b1; sck0 = 1'b0; sck1 = 1'b1; sd = 1'b0;
    rdy0 = 1'b0; rdy1 = 1'b0;
    tick(3);
    check("rst_out_valid", 32'(ov0), 32'd0);
    check("rst_out_data", 32'(od0), 32'd0);
    check("rst_frame_words", 32'(fw0), 32'd0);
    check("rst_busy", 32'(bz0), 32'd0);
    check("rst_frame_err", 32'(fe0), 32'd0);
    check("rst_overflow", 32'(of0), 32'd0);

    // Two-word frame, release with slv high
    rst = 1'b0;
    tick(5);
    rdy0 = 1'b1;
    frame_start();
    check("busy_in_frame", 32'(bz0), 32'd1);
    send_word(1'b0, 12'hABC, 1'b0);
    send_word(1'b0, 12'h123, 1'b0);
    frame_end();
    check("f1_count", 32'(rxq.size()), 32'd2);
    check("f1_word0", q_at(0), 32'hABC);
    check("f1_word1", q_at(1), 32'h123);
    check("f1_frame_words", 32'(fw0), 32'd2);
    check("f1_no_err", 32'(err_cnt), 32'd0);
    check("f1_busy_after", 32'(bz0), 32'd0);

    // Reset released mid-frame: partial activity ignored
    rst = 1'b1; slv = 1'b0;
    tick(2);
    rst = 1'b0;
    rxq.delete();
    tick(4);
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    frame_end();
    check("mid_no_output", 32'(rxq.size()), 32'd0);
    check("mid_no_err", 32'(err_cnt), 32'd0);
    check("mid_frame_words", 32'(fw0), 32'd0);
    check("mid_not_busy", 32'(bz0), 32'd0);
    frame_start();
    send_word(1'b0, 12'h5A5, 1'b0);
    frame_end();
    check("f2_count", 32'(rxq.size()), 32'd1);
    check("f2_word", q_at(0), 32'h5A5);
    check("f2_frame_words", 32'(fw0), 32'd1);

    // Full word then a 7-bit tail
    rxq.delete();
    frame_start();
    send_word(1'b0, 12'hFFF, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'(i & 1), 1'b0);
    check("tail_err_before_end", 32'(err_cnt), 32'd0);
    frame_end();
    check("tail_word", q_at(0), 32'hFFF);
    check("tail_err_pulse", 32'(err_cnt), 32'd1);
    check("tail_frame_words", 32'(fw0), 32'd1);

    // Fill the FIFO with ready low, 17th word overflows
    rdy0 = 1'b0;
    rxq.delete();
    err_cnt = 0;
    frame_start();
    for (int i = 0; i < 16; i++) send_word(1'b0, DW'(i), 1'b0);
    tick(4);
    check("fill_no_ovf", 32'(ovf_cnt), 32'd0);
    check("fill_head_valid", 32'(ov0), 32'd1);
    check("fill_head_data", 32'(od0), 32'h000);
    send_word(1'b0, 12'h010, 1'b0);
    tick(4);
    check("ovf_once", 32'(ovf_cnt), 32'd1);
    check("ovf_head_stable", 32'(od0), 32'h000);
    frame_end();
    check("ovf_frame_words", 32'(fw0), 32'd17);

    // Full FIFO, pop coincides with the push: word accepted at the tail
    frame_start();
    send_word(1'b0, 12'h0AA, 1'b1);
    frame_end();
    check("fullpop_no_ovf", 32'(ovf_cnt), 32'd1);
    check("fullpop_popped", 32'(rxq.size()), 32'd1);
    rdy0 = 1'b1;
    tick(40);
    check("drain_count", 32'(rxq.size()), 32'd17);
    for (int i = 0; i < 16; i++) check($sformatf("drain_%0d", i), q_at(i), 32'(i));
    check("drain_tail", q_at(16), 32'h0AA);
    check("drain_empty", 32'(ov0), 32'd0);

    // CPOL=1 instance samples on falling sckv
    frame_start();
    send_word(1'b1, 12'h800, 1'b0);
    frame_end();
    check("cpol1_valid", 32'(ov1), 32'd1);
    check("cpol1_data", 32'(od1), 32'h800);
    check("cpol1_frame_words", 32'(fw1), 32'd1);
    check("cpol1_dut0_idle", 32'(ov0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
